// File: rtl/i2c_pid_cfg_target.sv
// I2C target holding the PID gains K_p/K_i/K_d (pointer-addressed, ID at 0x3).
// Define I2C_GLITCH_FILTER_EN to add a 3-sample majority filter after the synchronizers.
module i2c_pid_cfg_target #(
    parameter logic [6:0] ADDR   = 7'h2A,
    parameter logic [5:0] KP_RST = 6'd0,
    parameter logic [5:0] KI_RST = 6'd0,
    parameter logic [5:0] KD_RST = 6'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [5:0] K_p,
    output logic [5:0] K_i,
    output logic [5:0] K_d,
    output logic       cfg_wr,
    output logic       busy
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
        ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RACK
    } state_t;

    state_t      state;
    logic [1:0]  scl_sync, sda_sync;
    logic        scl_f, sda_f, scl_p, sda_p;
    logic [7:0]  sh, ptr, rd_byte, next_ptr;
    logic [3:0]  cnt;
    logic        rw;

    // Idle bus is high, so reset the input path high to avoid a false edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    logic [2:0] scl_hist, sda_hist;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_hist <= 3'b111;
            sda_hist <= 3'b111;
        end else begin
            scl_hist <= {scl_hist[1:0], scl_sync[1]};
            sda_hist <= {sda_hist[1:0], sda_sync[1]};
        end
    end
    assign scl_f = (scl_hist[0] & scl_hist[1]) | (scl_hist[0] & scl_hist[2]) | (scl_hist[1] & scl_hist[2]);
    assign sda_f = (sda_hist[0] & sda_hist[1]) | (sda_hist[0] & sda_hist[2]) | (sda_hist[1] & sda_hist[2]);
`else
    assign scl_f = scl_sync[1];
    assign sda_f = sda_sync[1];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_p <= 1'b1;
            sda_p <= 1'b1;
        end else begin
            scl_p <= scl_f;
            sda_p <= sda_f;
        end
    end

    wire scl_rise = scl_f & ~scl_p;
    wire scl_fall = ~scl_f & scl_p;
    wire start    = scl_f & scl_p & sda_p & ~sda_f;
    wire stop     = scl_f & scl_p & ~sda_p & sda_f;

    always_comb begin
        case (ptr[1:0])
            2'd0:    rd_byte = {2'b00, K_p};
            2'd1:    rd_byte = {2'b00, K_i};
            2'd2:    rd_byte = {2'b00, K_d};
            default: rd_byte = 8'hD1;
        endcase
    end

    assign next_ptr = (ptr[1:0] == 2'd3) ? 8'd0 : ptr + 8'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            sda_oe <= 1'b0;
            cfg_wr <= 1'b0;
            busy   <= 1'b0;
            K_p    <= KP_RST;
            K_i    <= KI_RST;
            K_d    <= KD_RST;
            ptr    <= 8'd0;
            sh     <= 8'd0;
            cnt    <= 4'd0;
            rw     <= 1'b0;
        end else begin
            cfg_wr <= 1'b0;
            if (!ena) begin
                state  <= ST_IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else if (start) begin
                state  <= ST_ADDR;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
                cnt    <= 4'd0;
            end else if (stop) begin
                state  <= ST_IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else begin
                if (scl_rise) begin
                    case (state)
                        ST_ADDR, ST_PTR, ST_WDATA: begin
                            sh  <= {sh[6:0], sda_f};
                            cnt <= cnt + 4'd1;
                        end
                        ST_RDATA: cnt <= cnt + 4'd1;
                        // Host ACK low advances the pointer; NACK ends the read.
                        ST_RACK: if (sda_f) state <= ST_IDLE; else ptr <= next_ptr;
                        default: ;
                    endcase
                end
                if (scl_fall) begin
                    case (state)
                        ST_ADDR: if (cnt == 4'd8) begin
                            if (sh[7:1] == ADDR) begin
                                state  <= ST_ADDR_ACK;
                                sda_oe <= 1'b1;
                                busy   <= 1'b1;
                                rw     <= sh[0];
                            end else begin
                                state  <= ST_IDLE;
                            end
                        end
                        ST_ADDR_ACK: begin
                            cnt <= 4'd0;
                            if (rw) begin
                                state  <= ST_RDATA;
                                sh     <= rd_byte;
                                sda_oe <= ~rd_byte[7];
                            end else begin
                                state  <= ST_PTR;
                                sda_oe <= 1'b0;
                            end
                        end
                        ST_PTR: if (cnt == 4'd8) begin
                            ptr    <= sh;
                            sda_oe <= 1'b1;
                            state  <= ST_PTR_ACK;
                        end
                        ST_PTR_ACK, ST_WDATA_ACK: begin
                            if (state == ST_WDATA_ACK) ptr <= next_ptr;
                            sda_oe <= 1'b0;
                            cnt    <= 4'd0;
                            state  <= ST_WDATA;
                        end
                        ST_WDATA: if (cnt == 4'd8) begin
                            sda_oe <= 1'b1;
                            state  <= ST_WDATA_ACK;
                            case (ptr[1:0])
                                2'd0: begin K_p <= sh[5:0]; cfg_wr <= 1'b1; end
                                2'd1: begin K_i <= sh[5:0]; cfg_wr <= 1'b1; end
                                2'd2: begin K_d <= sh[5:0]; cfg_wr <= 1'b1; end
                                default: ;
                            endcase
                        end
                        ST_RDATA: if (cnt == 4'd8) begin
                            sda_oe <= 1'b0;
                            state  <= ST_RACK;
                        end else begin
                            sh     <= {sh[6:0], 1'b0};
                            sda_oe <= ~sh[6];
                        end
                        ST_RACK: begin
                            cnt    <= 4'd0;
                            state  <= ST_RDATA;
                            sh     <= rd_byte;
                            sda_oe <= ~rd_byte[7];
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_pid_cfg_target.sv
// Bench for i2c_pid_cfg_target: bit-banged host, open-drain bus model, read scoreboard.
module tb_i2c_pid_cfg_target;

    localparam int Q = 8;  // quarter SCL period in clk cycles

    logic       clk = 1'b0, rst_n = 1'b0, ena = 1'b1, scl = 1'b1, hsda = 1'b1;
    logic       sda_oe, cfg_wr, busy;
    logic [5:0] K_p, K_i, K_d;
    wire        sda_line = hsda & ~sda_oe;

    i2c_pid_cfg_target dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .scl_in(scl), .sda_in(sda_line),
        .sda_oe(sda_oe), .K_p(K_p), .K_i(K_i), .K_d(K_d), .cfg_wr(cfg_wr), .busy(busy)
    );

    always #5 clk = ~clk;

    int         checks = 0, failures = 0, wr_cnt = 0;
    bit         oe_seen, busy_seen;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0]  ptr;
        int          n;
        logic [23:0] d;
        logic [5:0]  kp, ki, kd;
        int          nwr;
    } vec_t;
    vec_t vt[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (cfg_wr) wr_cnt++;
        if (sda_oe) oe_seen = 1'b1;
        if (busy) busy_seen = 1'b1;
    end

    // Gain updates must coincide with the ACK pull-down.
    always @(negedge clk) if (cfg_wr) chk("cfg_wr_with_ack", {31'd0, sda_oe}, 32'd1);

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_x(input logic b, output logic smp);
        hsda = b; tick(Q);
        scl = 1'b1; tick(Q);
        smp = sda_line; tick(Q);
        scl = 1'b0; tick(Q);
    endtask

    task automatic i2c_start();
        hsda = 1'b0; tick(Q);
        scl = 1'b0; tick(Q);
    endtask

    task automatic i2c_rstart();
        hsda = 1'b1; tick(Q);
        scl = 1'b1; tick(Q);
        hsda = 1'b0; tick(Q);
        scl = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        hsda = 1'b0; tick(Q);
        scl = 1'b1; tick(Q);
        hsda = 1'b1; tick(Q);
    endtask

    task automatic wr_byte(input string name, input logic [7:0] b, input logic exp_ack);
        logic s, ack;
        for (int i = 7; i >= 0; i--) bit_x(b[i], s);
        bit_x(1'b1, s);
        ack = ~s;
        chk(name, {31'd0, ack}, {31'd0, exp_ack});
    endtask

    task automatic rd_byte(input logic ack);
        logic [7:0] v;
        logic       s, e;
        logic [7:0] exp_b;
        v = 8'd0;
        for (int i = 0; i < 8; i++) begin
            bit_x(1'b1, s);
            v = {v[6:0], s};
        end
        e = ~ack;
        bit_x(e, s);
        if (exp_q.size() > 0) begin
            exp_b = exp_q.pop_front();
            chk("rd_data", {24'd0, v}, {24'd0, exp_b});
        end else begin
            checks++;
            failures++;
            $display("FAIL rd_data actual=%0h expected=<none queued>", v);
        end
    endtask

    task automatic wr_txn(input logic [7:0] p, input int n, input logic [23:0] d);
        i2c_start();
        wr_byte("addr_ack", 8'h54, 1'b1);
        wr_byte("ptr_ack", p, 1'b1);
        for (int j = 0; j < n; j++) wr_byte("data_ack", d[23-8*j -: 8], 1'b1);
        i2c_stop();
        tick(4);
    endtask

    initial begin
        int  w0;
        logic s;
        vt[0] = '{8'h00, 1, 24'h150000, 6'h15, 6'h00, 6'h00, 1};
        vt[1] = '{8'h00, 3, 24'h3FC70A, 6'h3F, 6'h07, 6'h0A, 3};
        vt[2] = '{8'h03, 2, 24'hAA2B00, 6'h2B, 6'h07, 6'h0A, 1};
        vt[3] = '{8'hFE, 1, 24'h0B0000, 6'h2B, 6'h07, 6'h0B, 1};
        vt[4] = '{8'h00, 3, 24'h3F070A, 6'h3F, 6'h07, 6'h0A, 3};

        tick(4);
        rst_n = 1'b1;
        tick(2);
        chk("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cfg_wr", {31'd0, cfg_wr}, 32'd0);
        chk("rst_gains", {14'd0, K_p, K_i, K_d}, 32'd0);

        for (int v = 0; v < 5; v++) begin
            w0 = wr_cnt;
            wr_txn(vt[v].ptr, vt[v].n, vt[v].d);
            chk("K_p", {26'd0, K_p}, {26'd0, vt[v].kp});
            chk("K_i", {26'd0, K_i}, {26'd0, vt[v].ki});
            chk("K_d", {26'd0, K_d}, {26'd0, vt[v].kd});
            chk("cfg_wr_count", wr_cnt - w0, vt[v].nwr);
        end

        // Pointer set, repeated START, 4-byte read wrapping through ID.
        i2c_start();
        wr_byte("rd_addr_w_ack", 8'h54, 1'b1);
        wr_byte("rd_ptr_ack", 8'h01, 1'b1);
        i2c_rstart();
        wr_byte("rd_addr_r_ack", 8'h55, 1'b1);
        chk("busy_in_read", {31'd0, busy}, 32'd1);
        exp_q.push_back(8'h07); rd_byte(1'b1);
        exp_q.push_back(8'h0A); rd_byte(1'b1);
        exp_q.push_back(8'hD1); rd_byte(1'b1);
        exp_q.push_back(8'h3F); rd_byte(1'b0);
        tick(2);
        chk("oe_after_nack", {31'd0, sda_oe}, 32'd0);
        i2c_stop();
        tick(4);
        chk("busy_after_stop", {31'd0, busy}, 32'd0);

        // Wrong address is ignored for the whole transfer.
        oe_seen = 1'b0; busy_seen = 1'b0;
        i2c_start();
        wr_byte("wrong_addr_nack", 8'h56, 1'b0);
        wr_byte("ignored_byte_nack", 8'h00, 1'b0);
        i2c_stop();
        tick(4);
        chk("wrong_addr_oe", {31'd0, oe_seen}, 32'd0);
        chk("wrong_addr_busy", {31'd0, busy_seen}, 32'd0);
        wr_txn(8'h01, 1, 24'h120000);
        chk("K_i_after_wrong", {26'd0, K_i}, 32'h12);

        // Partial data byte then STOP: no update.
        w0 = wr_cnt;
        i2c_start();
        wr_byte("part_addr_ack", 8'h54, 1'b1);
        wr_byte("part_ptr_ack", 8'h02, 1'b1);
        bit_x(1'b1, s); bit_x(1'b0, s); bit_x(1'b1, s); bit_x(1'b0, s);
        i2c_stop();
        tick(4);
        chk("K_d_partial", {26'd0, K_d}, 32'h0A);
        chk("cfg_wr_partial", wr_cnt - w0, 0);
        wr_txn(8'h02, 1, 24'h210000);
        chk("K_d_after_partial", {26'd0, K_d}, 32'h21);

        // Reset in the middle of a data byte (bit 5).
        i2c_start();
        wr_byte("rst_addr_ack", 8'h54, 1'b1);
        wr_byte("rst_ptr_ack", 8'h00, 1'b1);
        bit_x(1'b1, s); bit_x(1'b0, s);
        hsda = 1'b1; tick(Q);
        scl = 1'b1; rst_n = 1'b0; tick(3);
        chk("midrst_gains", {14'd0, K_p, K_i, K_d}, 32'd0);
        chk("midrst_sda_oe", {31'd0, sda_oe}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1; tick(Q);
        scl = 1'b0; tick(Q);
        i2c_stop();
        tick(4);

        // Disabled target must not respond.
        ena = 1'b0; oe_seen = 1'b0;
        i2c_start();
        wr_byte("ena_low_nack", 8'h54, 1'b0);
        i2c_stop();
        tick(4);
        chk("ena_low_oe", {31'd0, oe_seen}, 32'd0);
        ena = 1'b1;
        tick(4);
        wr_txn(8'h00, 1, 24'h2A0000);
        chk("K_p_after_ena", {26'd0, K_p}, 32'h2A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
